// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the ADC scan sequencer: FSM encoding and
// the AdcReceiver configuration word builder.
package adc_seq_pkg;

    localparam int unsigned NUM_CH_W    = 3;
    localparam logic        ADC_CFG_SGL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_REQUEST = 3'd2,
        ST_CONVERT = 3'd3,
        ST_STORE   = 3'd4
    } state_t;

    function automatic logic [5:0] adc_cfg_word(input logic [NUM_CH_W-1:0] ch);
        return {ADC_CFG_SGL, ch, 2'b00};
    endfunction

endpackage

// File: rtl/adc_scan_tick.sv
// Enable-gated free-running period counter; o_tick is high for the one
// cycle in which the counter wraps.
module adc_scan_tick #(
    parameter int unsigned CLKS_PER_SCAN = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_SCAN);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(CLKS_PER_SCAN - 1));
    assign o_tick = i_enable && w_wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_enable || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Periodic / single-shot multi-channel scan controller driving one AdcReceiver,
// with a per-channel result bank and a result stream.
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned NUM_CH        = 8,
    parameter int unsigned CLKS_PER_SCAN = 50000,
    parameter int unsigned TIMEOUT_CLKS  = 4096,
    parameter int unsigned DATA_W        = 12
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic                i_single_shot,
    input  logic [NUM_CH-1:0]   i_ch_mask,
    output logic                o_busy,
    output logic                o_result_dv,
    output logic [NUM_CH_W-1:0] o_result_ch,
    output logic [DATA_W-1:0]   o_result_data,
    output logic                o_timeout,
    input  logic [NUM_CH_W-1:0] i_rd_ch,
    output logic [DATA_W-1:0]   o_rd_data,
    output logic                o_adc_request_conversion,
    output logic [5:0]          o_adc_tx_bits,
    input  logic                i_adc_conv_in_process,
    input  logic                i_adc_rx_dv,
    input  logic [DATA_W-1:0]   i_adc_rx_data
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS);
    // Compared against the pre-increment count so o_timeout is visible
    // exactly TIMEOUT_CLKS-1 cycles after the request rises.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 2);

    state_t              r_state;
    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH_W-1:0] r_ch_ptr;
    logic [NUM_CH_W-1:0] r_ch;
    logic [TMO_W-1:0]    r_tmo;
    logic [DATA_W-1:0]   r_bank [NUM_CH];

    logic                w_tick;
    logic                w_found;
    logic [NUM_CH_W-1:0] w_pick;

    adc_scan_tick #(.CLKS_PER_SCAN(CLKS_PER_SCAN)) u_tick (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (i_enable),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!w_found && r_mask[i] && (i >= 32'(r_ch_ptr))) begin
                w_found = 1'b1;
                w_pick  = NUM_CH_W'(i);
            end
        end
    end

    assign o_rd_data = r_bank[i_rd_ch];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state                  <= ST_IDLE;
            r_mask                   <= '0;
            r_ch_ptr                 <= '0;
            r_ch                     <= '0;
            r_tmo                    <= '0;
            o_busy                   <= 1'b0;
            o_result_dv              <= 1'b0;
            o_result_ch              <= '0;
            o_result_data            <= '0;
            o_timeout                <= 1'b0;
            o_adc_request_conversion <= 1'b0;
            o_adc_tx_bits            <= adc_cfg_word('0);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            o_result_dv <= 1'b0;
            o_timeout   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick || i_single_shot) begin
                        r_mask   <= i_ch_mask;
                        r_ch_ptr <= '0;
                        if (i_ch_mask != '0) begin
                            r_state <= ST_SELECT;
                            o_busy  <= 1'b1;
                        end
                    end
                end
                ST_SELECT: begin
                    if (w_found) begin
                        r_ch                     <= w_pick;
                        o_adc_tx_bits            <= adc_cfg_word(w_pick);
                        o_adc_request_conversion <= 1'b1;
                        r_tmo                    <= '0;
                        r_state                  <= ST_REQUEST;
                    end else begin
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                ST_REQUEST: begin
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (r_tmo == TMO_LAST) begin
                        o_timeout                <= 1'b1;
                        o_adc_request_conversion <= 1'b0;
                        r_state                  <= ST_STORE;
                    end else if (i_adc_conv_in_process) begin
                        o_adc_request_conversion <= 1'b0;
                        r_state                  <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (i_adc_rx_dv) begin
                        r_bank[r_ch]  <= i_adc_rx_data;
                        o_result_dv   <= 1'b1;
                        o_result_ch   <= r_ch;
                        o_result_data <= i_adc_rx_data;
                        r_state       <= ST_STORE;
                    end else if (r_tmo == TMO_LAST) begin
                        o_timeout <= 1'b1;
                        r_state   <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    if (r_ch == NUM_CH_W'(NUM_CH - 1)) begin
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end else begin
                        r_ch_ptr <= r_ch + NUM_CH_W'(1);
                        r_state  <= ST_SELECT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
